reg_share_arbiter: RTL and testbench
====================================

Name: reg_share_arbiter

Overview:
Round-robin arbiter that shares one n-bit holding register among NREQ requesters. Each requester presents a request and a data word. The arbiter grants one requester at a time, loads that requester's word into the shared register, and reports which requester owns the current contents. It sits in front of a shared pipeline/config register so several producers can update it without conflicts.

Parameters:
n, 8, data width of the shared register and of each requester word
NREQ, 4, number of requesters (2..16)
IDW, 2, width of the owner index; must be at least ceil(log2(NREQ))
MAX_HOLD, 8, maximum consecutive loads in LOCKED state (1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
req  input  NREQ  per-requester request; bit i belongs to requester i
lock  input  NREQ  per-requester lock request; used only with ARB_LOCK_EN
dataIn  input  NREQ*n  flattened data words; requester i occupies [i*n +: n]
grant  output  NREQ  one-hot registered grant; all zeros when idle
dataOut  output  n  shared register contents
ownerId  output  IDW  index of the requester whose word is in dataOut
loadValid  output  1  one-cycle pulse; dataOut/ownerId were updated at the previous edge
busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs and state are registered; no combinational path from inputs to outputs.
- Reset (reset==0 at a clk edge): state=IDLE, grant=0, dataOut=0, ownerId=0, loadValid=0, rotation pointer ptr=0, hold counter=0. Reset has priority over everything, in every state.
- States: IDLE, GRANT, LOCKED.
- IDLE: if any req bit is high, pick the winner w = the first requester with req high, searching from ptr upward and wrapping from NREQ-1 to 0. Then grant<=onehot(w) and state<=GRANT. If no req bit is high, stay in IDLE with grant=0.
- GRANT (grant[w]=1 for exactly one cycle), at the closing edge:
  - If req[w]==1: dataOut<=dataIn[w], ownerId<=w, loadValid<=1, ptr<=(w+1) mod NREQ, hold counter<=1.
  - If req[w]==0 (withdrawn): no load, loadValid stays 0, ptr unchanged, grant<=0, state<=IDLE.
  - After a load, go to LOCKED if ARB_LOCK_EN is defined, lock[w]==1 and MAX_HOLD>1. Otherwise grant<=0 and state<=IDLE.
- LOCKED (grant[w] held):
  - Each cycle with req[w]==1 and lock[w]==1: load dataIn[w] with loadValid=1, increment hold counter.
  - When the counter reaches MAX_HOLD, or lock[w]==0, or req[w]==0: stop loading, grant<=0, state<=IDLE. A final load occurs only on the cycle that hits MAX_HOLD.
- Minimum spacing without lock: one load every 2 cycles (IDLE→GRANT→IDLE). A request arriving during GRANT/LOCKED waits; it is not dropped.
- Requesters must hold req and dataIn stable until they see their grant bit. Data is sampled at the closing edge of the grant cycle.
- loadValid is low in every cycle that does not immediately follow a load edge.
- Fairness: a continuously requesting requester is granted within NREQ grants (NREQ*MAX_HOLD loads when locks are used).
- ownerId and dataOut hold their values while idle; they change only on a load.

Optional Feature:
ARB_LOCK_EN: when defined, the LOCKED state and hold counter are built, and a locked requester gets up to MAX_HOLD back-to-back loads. When undefined, the lock input is ignored, LOCKED is never entered, the hold counter is not synthesised, and every grant lasts exactly one cycle.

Test Plan:
- Reset: drive reset=0 for 2 cycles with req=4'b1111 → grant=0, dataOut=0, ownerId=0, loadValid=0, busy=0. Repeat with reset asserted mid-LOCKED → same values at the next edge.
- Single request: req=4'b0100 and dataIn[2]=8'h5A at cycle 1 → grant=4'b0100 in cycle 2; dataOut=8'h5A, ownerId=2 and loadValid=1 in cycle 3; grant=0 in cycle 3.
- Round robin: req=4'b1111 held, dataIn[i]=8'h10+i → loads in order 0,1,2,3,0 with dataOut 8'h10,8'h11,8'h12,8'h13,8'h10, one load every 2 cycles.
- Withdrawal: req=4'b0010, then req dropped to 0 during the grant cycle → no loadValid, dataOut unchanged, ptr unchanged; the next req=4'b0011 grants requester 0 first.
- Lock (ARB_LOCK_EN, MAX_HOLD=8): req=4'b1001, lock=4'b0001 held → 8 consecutive loads from requester 0 with loadValid high for 8 cycles, then the next grant goes to requester 3.
- Lock disabled build: same stimulus as the lock test → requesters 0 and 3 alternate, one load each per 2 cycles.

Source files
------------

// File: rtl/reg_share_arbiter_if.sv
// Request/grant bundle between producers and the shared-register arbiter.
// The requester side is the master modport and the arbiter side is the slave modport.
interface reg_share_arbiter_if #(
    parameter int unsigned n    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*n-1:0] dataIn;
    logic [NREQ-1:0]   grant;
    logic [n-1:0]      dataOut;
    logic [IDW-1:0]    ownerId;
    logic              loadValid;
    logic              busy;

    modport master (
        output req, lock, dataIn,
        input  grant, dataOut, ownerId, loadValid, busy
    );

    modport slave (
        input  req, lock, dataIn,
        output grant, dataOut, ownerId, loadValid, busy
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared register.
// Define ARB_LOCK_EN to build the LOCKED state, which gives a requester up to MAX_HOLD
// back-to-back loads.
module reg_share_arbiter #(
    parameter int unsigned n        = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic               clk,
    input logic               reset,
    reg_share_arbiter_if.slave arb
);

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [n-1:0]    data_q, data_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic            valid_q, valid_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win;
    logic            found;
    logic [IDW-1:0]  next_ptr;

`ifdef ARB_LOCK_EN
    logic [7:0] hold_q, hold_d;
`else
    logic unused_lock;
    assign unused_lock = ^arb.lock;
`endif

    // Search for the first request at or above ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_q) + i >= NREQ) ? IDW'(int'(ptr_q) + i - NREQ)
                                             : IDW'(int'(ptr_q) + i);
            if (!found && arb.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign next_ptr = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        owner_d = owner_q;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        win_d   = win_q;
`ifdef ARB_LOCK_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    win_d   = win;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                grant_d = '0;
                state_d = StIdle;
                if (arb.req[win_q]) begin
                    data_d  = arb.dataIn[int'(win_q)*n +: n];
                    owner_d = win_q;
                    valid_d = 1'b1;
                    ptr_d   = next_ptr;
`ifdef ARB_LOCK_EN
                    hold_d  = 8'd1;
                    if (arb.lock[win_q] && MAX_HOLD > 1) begin
                        grant_d = grant_q;
                        state_d = StLocked;
                    end
`endif
                end
            end
`ifdef ARB_LOCK_EN
            StLocked: begin
                grant_d = '0;
                state_d = StIdle;
                if (arb.req[win_q] && arb.lock[win_q]) begin
                    data_d  = arb.dataIn[int'(win_q)*n +: n];
                    owner_d = win_q;
                    valid_d = 1'b1;
                    hold_d  = hold_q + 8'd1;
                    // Keep the grant unless this load used up the hold budget.
                    if (hold_q + 8'd1 != 8'(MAX_HOLD)) begin
                        grant_d = grant_q;
                        state_d = StLocked;
                    end
                end
            end
`endif
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            data_q  <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign arb.grant     = grant_q;
    assign arb.dataOut   = data_q;
    assign arb.ownerId   = owner_q;
    assign arb.loadValid = valid_q;
    assign arb.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: a vector table for reset, single-request,
// round-robin and withdrawal behaviour, plus sequences for mid-activity reset and lock.
module tb_reg_share_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    reg_share_arbiter_if #(.n(8), .NREQ(4), .IDW(2)) arb ();

    reg_share_arbiter #(.n(8), .NREQ(4), .IDW(2), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] din;
        logic [3:0]  eg;
        logic [7:0]  ed;
        logic [1:0]  eo;
        logic        ev;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] DinRr  = 32'h13121110;
    localparam logic [31:0] DinOne = 32'h135A1110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] g, input logic [7:0] dout, input logic [1:0] o,
                       input logic v, input logic b);
        vec_t x;
        x.rst_n = r; x.req = rq; x.lock = 4'b0000; x.din = d;
        x.eg = g; x.ed = dout; x.eo = o; x.ev = v; x.eb = b;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {16'h0, arb.grant, arb.dataOut, arb.ownerId, arb.loadValid, arb.busy};
    endfunction

    initial begin
        arb.req = '0;
        arb.lock = '0;
        arb.dataIn = '0;

        // Reset held with all requests high
        add(0, 4'b1111, DinRr,  4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b1111, DinRr,  4'b0000, 8'h00, 0, 0, 0);
        // Single request from requester 2
        add(1, 4'b0100, DinOne, 4'b0100, 8'h00, 0, 0, 1);
        add(1, 4'b0100, DinOne, 4'b0000, 8'h5A, 2, 1, 0);
        add(1, 4'b0000, DinOne, 4'b0000, 8'h5A, 2, 0, 0);
        // Round robin from ptr=0
        add(0, 4'b1111, DinRr,  4'b0000, 8'h00, 0, 0, 0);
        add(1, 4'b1111, DinRr,  4'b0001, 8'h00, 0, 0, 1);
        add(1, 4'b1111, DinRr,  4'b0000, 8'h10, 0, 1, 0);
        add(1, 4'b1111, DinRr,  4'b0010, 8'h10, 0, 0, 1);
        add(1, 4'b1111, DinRr,  4'b0000, 8'h11, 1, 1, 0);
        add(1, 4'b1111, DinRr,  4'b0100, 8'h11, 1, 0, 1);
        add(1, 4'b1111, DinRr,  4'b0000, 8'h12, 2, 1, 0);
        add(1, 4'b1111, DinRr,  4'b1000, 8'h12, 2, 0, 1);
        add(1, 4'b1111, DinRr,  4'b0000, 8'h13, 3, 1, 0);
        add(1, 4'b1111, DinRr,  4'b0001, 8'h13, 3, 0, 1);
        add(1, 4'b1111, DinRr,  4'b0000, 8'h10, 0, 1, 0);
        // Requester 3 alone leaves ptr at 0
        add(1, 4'b1000, DinRr,  4'b1000, 8'h10, 0, 0, 1);
        add(1, 4'b1000, DinRr,  4'b0000, 8'h13, 3, 1, 0);
        // Withdrawal during grant: no load, ptr stays 0
        add(1, 4'b0010, DinRr,  4'b0010, 8'h13, 3, 0, 1);
        add(1, 4'b0000, DinRr,  4'b0000, 8'h13, 3, 0, 0);
        add(1, 4'b0011, DinRr,  4'b0001, 8'h13, 3, 0, 1);
        add(1, 4'b0011, DinRr,  4'b0000, 8'h10, 0, 1, 0);

        foreach (vecs[k]) begin
            reset = vecs[k].rst_n;
            arb.req = vecs[k].req;
            arb.lock = vecs[k].lock;
            arb.dataIn = vecs[k].din;
            step();
            check($sformatf("row%0d {grant,dataOut,ownerId,loadValid,busy}", k), outs(),
                  {16'h0, vecs[k].eg, vecs[k].ed, vecs[k].eo, vecs[k].ev, vecs[k].eb});
        end

        // Reset asserted mid-activity (LOCKED with the lock build, GRANT otherwise)
        reset = 1'b0;
        arb.req = '0;
        arb.lock = '0;
        step();
        reset = 1'b1;
        arb.req = 4'b0001;
        arb.lock = 4'b0001;
        arb.dataIn = DinRr;
        step();
        step();
        step();
        check("busy before mid reset", {31'h0, arb.busy}, 32'h1);
        reset = 1'b0;
        step();
        check("mid reset outputs", outs(), 32'h0);

        // Lock stimulus: req 0 and 3, only requester 0 asks to lock
        reset = 1'b1;
        arb.req = 4'b1001;
        arb.lock = 4'b0001;
        step();
        check("lock first grant", {28'h0, arb.grant}, 32'h1);
`ifdef ARB_LOCK_EN
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("locked load %0d {dataOut,ownerId,loadValid}", i),
                  {21'h0, arb.dataOut, arb.ownerId, arb.loadValid},
                  {21'h0, 8'h10, 2'd0, 1'b1});
        end
        check("grant released at hold limit", {28'h0, arb.grant}, 32'h0);
        step();
        check("after lock grant goes to 3", {27'h0, arb.grant, arb.loadValid}, {27'h0, 4'b1000, 1'b0});
        step();
        check("requester 3 load", {21'h0, arb.dataOut, arb.ownerId, arb.loadValid},
              {21'h0, 8'h13, 2'd3, 1'b1});
`else
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("alt load0 %0d", i),
                  {17'h0, arb.grant, arb.dataOut, arb.ownerId, arb.loadValid},
                  {17'h0, 4'b0000, 8'h10, 2'd0, 1'b1});
            step();
            check($sformatf("alt grant3 %0d", i), {27'h0, arb.grant, arb.loadValid},
                  {27'h0, 4'b1000, 1'b0});
            step();
            check($sformatf("alt load3 %0d", i),
                  {17'h0, arb.grant, arb.dataOut, arb.ownerId, arb.loadValid},
                  {17'h0, 4'b0000, 8'h13, 2'd3, 1'b1});
            step();
            check($sformatf("alt grant0 %0d", i), {27'h0, arb.grant, arb.loadValid},
                  {27'h0, 4'b0001, 1'b0});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
